// File: rtl/mem_addr_manager.sv
// mem_addr_manager: qualifies load/store requests and registers the window-relative physical address.
// Optional MEM_ADDR_WRAP_EN: out-of-window single requests wrap into the window instead of faulting.
module mem_addr_manager #(
    parameter int                ADDR_W        = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
    parameter int                MEM_SIZE_LOG2 = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] input_address,
    output logic [ADDR_W-1:0] output_address,
    output logic              addr_valid,
    output logic              access_is_write,
    output logic              addr_fault
);
    localparam logic [ADDR_W:0] WIN_SIZE = (ADDR_W+1)'(1) << MEM_SIZE_LOG2;
    logic              single;
    logic              accept;
    logic              reject;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] phys;
`ifdef MEM_ADDR_WRAP_EN
    localparam logic [ADDR_W-1:0] WIN_MASK = ADDR_W'(WIN_SIZE - (ADDR_W+1)'(1));
    always_comb begin
        single = read_enable ^ write_enable;
        offset = input_address - BASE_ADDR;
        accept = single;
        phys   = offset & WIN_MASK;
        reject = (read_enable | write_enable) & ~accept;
    end
`else
    // one extra bit keeps the window end from overflowing at the top of the address space
    localparam logic [ADDR_W:0] WIN_LAST = {1'b0, BASE_ADDR} + WIN_SIZE - (ADDR_W+1)'(1);
    logic [ADDR_W:0] addr_ext;
    logic            in_window;
    always_comb begin
        single    = read_enable ^ write_enable;
        offset    = input_address - BASE_ADDR;
        addr_ext  = {1'b0, input_address};
        in_window = (addr_ext >= {1'b0, BASE_ADDR}) && (addr_ext <= WIN_LAST);
        accept    = single & in_window;
        phys      = offset;
        reject    = (read_enable | write_enable) & ~accept;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            output_address  <= '0;
            addr_valid      <= 1'b0;
            access_is_write <= 1'b0;
            addr_fault      <= 1'b0;
        end else begin
            addr_valid <= accept;
            addr_fault <= reject;
            if (accept) begin
                output_address  <= phys;
                access_is_write <= write_enable;
            end
        end
    end
endmodule

// File: tb/tb_mem_addr_manager.sv
// tb_mem_addr_manager: random and directed stimulus on a full-range and a windowed instance,
// checked every cycle against an arithmetic reference model plus literal expectations.
module tb_mem_addr_manager;
    localparam int B1 = 16'h4000;
    localparam int L1 = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] oa0, oa1;
    logic        v0, v1, w0, w1, f0, f1;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    int m_oa[2];
    bit m_v[2], m_w[2], m_f[2];

    always #5 clk = ~clk;

    mem_addr_manager dut0 (
        .clk(clk), .rst(rst), .read_enable(re), .write_enable(we), .input_address(addr),
        .output_address(oa0), .addr_valid(v0), .access_is_write(w0), .addr_fault(f0)
    );

    mem_addr_manager #(.ADDR_W(16), .BASE_ADDR(16'h4000), .MEM_SIZE_LOG2(12)) dut1 (
        .clk(clk), .rst(rst), .read_enable(re), .write_enable(we), .input_address(addr),
        .output_address(oa1), .addr_valid(v1), .access_is_write(w1), .addr_fault(f1)
    );

    // Reference model: whole-integer window arithmetic, one entry per instance.
    always @(posedge clk) begin
        started <= 1'b1;
        for (int k = 0; k < 2; k++) begin
            int base, size, a;
            bit inw, wrap;
            base = (k == 0) ? 0 : B1;
            size = (k == 0) ? 65536 : (1 << L1);
            a    = int'(addr);
            inw  = (a >= base) && (a <= base + size - 1);
`ifdef MEM_ADDR_WRAP_EN
            wrap = 1'b1;
`else
            wrap = 1'b0;
`endif
            if (rst) begin
                m_oa[k] <= 0; m_v[k] <= 0; m_w[k] <= 0; m_f[k] <= 0;
            end else if (re && we) begin
                m_v[k] <= 0; m_f[k] <= 1;
            end else if (re || we) begin
                if (inw || wrap) begin
                    m_oa[k] <= ((a - base) % 65536 + 65536) % size;
                    m_w[k]  <= we;
                    m_v[k]  <= 1;
                    m_f[k]  <= 0;
                end else begin
                    m_v[k] <= 0; m_f[k] <= 1;
                end
            end else begin
                m_v[k] <= 0; m_f[k] <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("d0_addr", oa0, 16'(m_oa[0]));
            chk("d0_valid", 16'(v0), 16'(m_v[0]));
            chk("d0_write", 16'(w0), 16'(m_w[0]));
            chk("d0_fault", 16'(f0), 16'(m_f[0]));
            chk("d1_addr", oa1, 16'(m_oa[1]));
            chk("d1_valid", 16'(v1), 16'(m_v[1]));
            chk("d1_write", 16'(w1), 16'(m_w[1]));
            chk("d1_fault", 16'(f1), 16'(m_f[1]));
        end
    end

    // Drive inputs, let one rising edge pass, return at the following falling edge.
    task automatic cyc(input logic r, input logic rd, input logic wr, input logic [15:0] a);
        rst = r; re = rd; we = wr; addr = a;
        @(negedge clk);
    endtask

    initial begin
        int sel;
        logic [15:0] ra;
        cyc(1, 1, 0, 16'h1234);
        chk("rst_addr", oa0, 16'h0000);
        chk("rst_valid", 16'(v0), 16'h0);
        cyc(1, 1, 0, 16'h1234);
        chk("rst2_addr", oa1, 16'h0000);
        chk("rst2_fault", 16'(f1), 16'h0);
        chk("rst2_write", 16'(w0), 16'h0);

        cyc(0, 1, 0, 16'h0000);
        chk("rd0_addr", oa0, 16'h0000);
        chk("rd0_valid", 16'(v0), 16'h1);
        chk("rd0_write", 16'(w0), 16'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 16'hFFFF);
            chk("idle_addr", oa0, 16'h0000);
            chk("idle_valid", 16'(v0), 16'h0);
        end

        cyc(0, 0, 1, 16'hFFFF);
        chk("wr_addr", oa0, 16'hFFFF);
        chk("wr_write", 16'(w0), 16'h1);
        chk("wr_valid", 16'(v0), 16'h1);
`ifndef MEM_ADDR_WRAP_EN
        chk("wr_win_fault", 16'(f1), 16'h1);
`endif

        cyc(0, 1, 0, 16'h0010);
        cyc(0, 1, 1, 16'h00AA);
        chk("coll_addr", oa0, 16'h0010);
        chk("coll_fault", 16'(f0), 16'h1);
        chk("coll_valid", 16'(v0), 16'h0);
        cyc(0, 0, 0, 16'h00AA);
        chk("coll_fault_drop", 16'(f0), 16'h0);

        cyc(0, 1, 0, 16'h4ABC);
        chk("win_addr", oa1, 16'h0ABC);
        chk("win_valid", 16'(v1), 16'h1);
        cyc(0, 1, 0, 16'h5000);
`ifdef MEM_ADDR_WRAP_EN
        chk("wrap_addr", oa1, 16'h0000);
        chk("wrap_valid", 16'(v1), 16'h1);
`else
        chk("oow_fault", 16'(f1), 16'h1);
        chk("oow_addr", oa1, 16'h0ABC);
`endif
        cyc(0, 1, 0, 16'h3FFF);
`ifndef MEM_ADDR_WRAP_EN
        chk("below_fault", 16'(f1), 16'h1);
`endif
        cyc(0, 0, 1, 16'h4FFF);
        chk("top_addr", oa1, 16'h0FFF);
        chk("top_write", 16'(w1), 16'h1);

        for (int i = 1; i <= 3; i++) begin
            cyc(0, 1, 0, 16'(i));
            chk("b2b_addr", oa0, 16'(i));
            chk("b2b_valid", 16'(v0), 16'h1);
        end

        cyc(1, 0, 1, 16'h4123);
        chk("midrst_addr", oa1, 16'h0000);
        chk("midrst_valid", 16'(v1), 16'h0);

        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 7));
            ra = (sel == 0) ? 16'h3FFF : (sel == 1) ? 16'h4000 : (sel == 2) ? 16'h4FFF :
                 (sel == 3) ? 16'h5000 : (sel == 4) ? 16'h4000 | 16'($urandom_range(0, 4095)) :
                 16'($urandom);
            cyc($urandom_range(0, 60) == 0, 1'($urandom), 1'($urandom), ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_addr_manager.md
Name: mem_addr_manager

Overview:
- Sits between the core's load/store unit and data memory.
- Qualifies each access request and translates the core's 16-bit logical address into a registered physical memory address, with window checking.
- Holds the last valid translated address whenever no access is requested, so the memory address bus stays stable between accesses.
- Flags illegal requests: out-of-window address, or read and write requested together.

Parameters:
- ADDR_W, 16, width of input and output addresses.
- BASE_ADDR, 16'h0000, first logical address of the memory window.
- MEM_SIZE_LOG2, 16, window size is 2**MEM_SIZE_LOG2 words; range 1..ADDR_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- read_enable  input  1  read access request for this cycle.
- write_enable  input  1  write access request for this cycle.
- input_address  input  ADDR_W  logical address from core.
- output_address  output  ADDR_W  registered physical address to memory.
- addr_valid  output  1  registered; 1 for one cycle after an accepted access.
- access_is_write  output  1  registered; direction of the last accepted access.
- addr_fault  output  1  registered; 1 for one cycle after a rejected request.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registered; latency is 1 cycle from request to output.
- Reset, sampled on a clk edge with rst=1: output_address=0, addr_valid=0, access_is_write=0, addr_fault=0. Reset overrides any simultaneous request. Reset mid-access discards that access.
- Window check:
  - in_window when BASE_ADDR <= input_address <= BASE_ADDR + 2**MEM_SIZE_LOG2 - 1.
  - Computed with ADDR_W+1-bit arithmetic, so the window end never overflows.
  - With default parameters, every 16-bit address is in window.
- Translation: phys = input_address - BASE_ADDR, truncated to ADDR_W bits, upper bits zero.
- Per-cycle decision (rst=0):
  - Neither enable high: output_address and access_is_write hold; addr_valid=0; addr_fault=0.
  - Exactly one enable high and in_window (accept): output_address<=phys; access_is_write<=write_enable; addr_valid<=1; addr_fault<=0.
  - Exactly one enable high and not in_window (reject): output_address and access_is_write hold; addr_valid<=0; addr_fault<=1.
  - Both enables high (reject): output_address and access_is_write hold; addr_valid<=0; addr_fault<=1.
- Enables are level-sensitive. Back-to-back accepted cycles update output_address every cycle. There is no internal state beyond the output registers.
- input_address is ignored whenever no enable is high.

Optional Feature:
- Macro: MEM_ADDR_WRAP_EN.
- Defined: out-of-window single-enable requests are accepted, not rejected.
  - phys = (input_address - BASE_ADDR) modulo 2**MEM_SIZE_LOG2, computed as the low MEM_SIZE_LOG2 bits of the subtraction.
  - addr_valid=1, addr_fault=0.
  - The both-enables case still faults.
- Not defined: out-of-window requests fault as described in Behaviour.

Test Plan:
- Reset: rst=1 for 2 cycles with read_enable=1, input_address=16'h1234 -> all outputs 0 on every edge while rst=1.
- Read then idle (defaults):
  - read_enable=1, input_address=16'h0000 -> next cycle output_address=16'h0000, addr_valid=1, access_is_write=0.
  - Then both enables 0 with input_address=16'hFFFF for 5 cycles -> output_address stays 16'h0000, addr_valid=0.
- Write: write_enable=1, input_address=16'hFFFF -> output_address=16'hFFFF, access_is_write=1, addr_valid=1.
- Collision: read_enable=1 and write_enable=1 with input_address=16'h00AA after an accepted 16'h0010 -> output_address stays 16'h0010, addr_fault=1 for one cycle.
- Window (BASE_ADDR=16'h4000, MEM_SIZE_LOG2=12):
  - read at 16'h4ABC -> output_address=16'h0ABC, addr_valid=1.
  - read at 16'h5000 -> addr_fault=1, output_address holds 16'h0ABC.
  - With MEM_ADDR_WRAP_EN defined, the 16'h5000 read instead gives output_address=16'h0000, addr_valid=1.
- Back-to-back: reads at 16'h0001, 16'h0002, 16'h0003 on consecutive cycles -> output_address follows one cycle later each cycle, addr_valid stays 1.
